// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl : multicycle MIPS control FSM with memory handshake,
//                        retired-instruction counter and sticky timeout fault.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_load,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal_op,
  output logic             fault,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_WAIT = 4'd4,
    S_WB_MEM   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_BRANCH   = 4'd9,
    S_FAULT    = 4'd15
  } state_t;

  localparam logic [5:0] c_OP_R    = 6'b000000;
  localparam logic [5:0] c_OP_LW   = 6'b100011;
  localparam logic [5:0] c_OP_SW   = 6'b101011;
  localparam logic [5:0] c_OP_BEQ  = 6'b000100;
  localparam logic [5:0] c_OP_ADDI = 6'b001000;
  // A waiting cycle that would push the count to MEM_TIMEOUT faults instead.
  localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_wait;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_timeout;
  logic             w_unused;

  // The zero flag is consumed by the datapath together with pc_write_cond.
  assign w_unused  = zero;
  assign w_timeout = (r_wait == c_WAIT_LAST);
  assign state     = r_state;
  assign retired   = r_retired;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_wait    <= 8'd0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire)
        r_retired <= r_retired + 1'b1;
      r_wait <= (mem_req && !mem_ready) ? r_wait + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_retire      = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_load       = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    aluop         = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_op    = 1'b0;
    fault         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run)
          w_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          c_OP_LW, c_OP_SW: w_next = S_MEM_ADDR;
          c_OP_R:           w_next = S_EXEC_R;
          c_OP_ADDI:        w_next = S_EXEC_I;
          c_OP_BEQ:         w_next = S_BRANCH;
          default: begin
            illegal_op = 1'b1;
            w_next     = S_IDLE;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == c_OP_SW);
        if (mem_ready) begin
          if (opcode == c_OP_SW) begin
            w_retire = 1'b1;
            w_next   = S_IDLE;
          end else begin
            w_next = S_WB_MEM;
          end
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_IDLE;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        aluop     = 2'b10;
        w_next    = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == c_OP_R);
        w_retire  = 1'b1;
        w_next    = S_IDLE;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aluop         = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        w_retire      = 1'b1;
        w_next        = S_IDLE;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl : scoreboard bench for the multicycle control FSM.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;
  localparam int TO = 4;
  localparam int CW = 3;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk = 1'b0, reset_n = 1'b0, run = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic mem_req, mem_we, iord, ir_load, pc_write, pc_write_cond;
  logic alu_src_a, reg_write, reg_dst, mem_to_reg, illegal_op, fault;
  logic [1:0] pc_source, alu_src_b, aluop;
  logic [3:0] state;
  logic [CW-1:0] retired;
  logic [24:0] obs;

  int checks = 0, failures = 0, exp_ret = 0;
  int rw_pulses = 0, ill_pulses = 0, memreq_cycles = 0;
  logic [24:0] sbq[$];

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_load(ir_load), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .aluop(aluop), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .fault(fault),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  assign obs = {state, mem_req, mem_we, iord, ir_load, pc_write, pc_write_cond,
                pc_source, alu_src_a, alu_src_b, aluop, reg_write, reg_dst,
                mem_to_reg, illegal_op, fault, retired};

  // Per-state output table transcribed from the control table.
  function automatic logic [24:0] exp_vec(input logic [3:0] st, input logic rdy,
                                          input logic [5:0] op, input logic [2:0] ret);
    logic mreq, mwe, io, irl, pcw, pcwc, asa, rw, rd, m2r, ill, flt;
    logic [1:0] pcs, asb, aop;
    {mreq, mwe, io, irl, pcw, pcwc, asa, rw, rd, m2r, ill, flt} = '0;
    {pcs, asb, aop} = '0;
    case (st)
      4'd1: begin mreq = 1; asb = 2'b01; irl = rdy; pcw = rdy; end
      4'd2: begin
        asb = 2'b11;
        ill = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI});
      end
      4'd3: begin asa = 1; asb = 2'b10; end
      4'd4: begin mreq = 1; io = 1; mwe = (op == OP_SW); end
      4'd5: begin rw = 1; m2r = 1; end
      4'd6: begin asa = 1; aop = 2'b10; end
      4'd7: begin asa = 1; asb = 2'b10; end
      4'd8: begin rw = 1; rd = (op == OP_R); end
      4'd9: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd15: flt = 1;
      default: ;
    endcase
    return {st, mreq, mwe, io, irl, pcw, pcwc, pcs, asa, asb, aop, rw, rd, m2r, ill, flt, ret};
  endfunction

  task automatic drive(input logic [3:0] st, input logic rdy, input logic r, input logic [5:0] op);
    @(negedge clk);
    mem_ready = rdy;
    run       = r;
    opcode    = op;
    sbq.push_back(exp_vec(st, rdy, op, 3'(exp_ret)));
    #1;
  endtask

  task automatic do_reset();
    logic [24:0] e;
    @(negedge clk);
    run = 0; mem_ready = 0; reset_n = 0;
    exp_ret = 0;
    sbq.push_back(exp_vec(4'd0, 1'b0, opcode, 3'd0));
    #1;
    e = sbq.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_state obs=%h exp=%h", obs, e); end
    @(negedge clk);
    reset_n = 1;
  endtask

  // One instruction: leading IDLE, FETCH with fd wait cycles, then the op path.
  task automatic exec_instr(input logic [5:0] op, input int fd, input int md, input string tag);
    logic [4:0] path[$];
    logic [24:0] e;
    logic legal;
    legal = 1'b1;
    path.push_back({4'd0, 1'b0});
    for (int k = 0; k <= fd; k++) path.push_back({4'd1, k == fd});
    path.push_back({4'd2, 1'b0});
    case (op)
      OP_R:    begin path.push_back({4'd6, 1'b0}); path.push_back({4'd8, 1'b0}); end
      OP_ADDI: begin path.push_back({4'd7, 1'b0}); path.push_back({4'd8, 1'b0}); end
      OP_BEQ:  path.push_back({4'd9, 1'b0});
      OP_LW, OP_SW: begin
        path.push_back({4'd3, 1'b0});
        for (int k = 0; k <= md; k++) path.push_back({4'd4, k == md});
        if (op == OP_LW) path.push_back({4'd5, 1'b0});
      end
      default: legal = 1'b0;
    endcase
    for (int i = 0; i < path.size(); i++) begin
      drive(path[i][4:1], path[i][0], 1'b1, op);
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s cyc%0d obs=%h exp=%h", tag, i, obs, e);
      end
      rw_pulses     += int'(reg_write);
      ill_pulses    += int'(illegal_op);
      memreq_cycles += int'(mem_req);
    end
    if (legal) exp_ret++;
  endtask

  task automatic test_reset();
    logic [24:0] e;
    @(negedge clk);
    reset_n = 0; run = 1; mem_ready = 1;
    for (int i = 0; i < 2; i++) begin
      sbq.push_back(exp_vec(4'd0, 1'b1, opcode, 3'd0));
      @(negedge clk); #1;
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL reset_hold obs=%h exp=%h", obs, e); end
    end
    do_reset();
  endtask

  task automatic test_r_type();
    logic [24:0] e;
    exec_instr(OP_R, 0, 0, "r_type");
    drive(4'd0, 1'b0, 1'b0, OP_R);
    e = sbq.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL r_type_retired obs=%h exp=%h", obs, e); end
  endtask

  task automatic test_lw();
    memreq_cycles = 0;
    exec_instr(OP_LW, 2, 2, "lw_delay");
    checks++;
    if (memreq_cycles !== 6) begin
      failures++; $display("FAIL lw_memreq_cycles obs=%0d exp=6", memreq_cycles);
    end
  endtask

  task automatic test_sw_beq();
    rw_pulses = 0;
    exec_instr(OP_SW, 0, 1, "sw");
    checks++;
    if (rw_pulses !== 0) begin
      failures++; $display("FAIL sw_reg_write obs=%0d exp=0", rw_pulses);
    end
    exec_instr(OP_BEQ, 0, 0, "beq");
    exec_instr(OP_ADDI, 1, 0, "addi");
  endtask

  task automatic test_illegal();
    logic [24:0] e;
    ill_pulses = 0;
    exec_instr(OP_BAD, 0, 0, "illegal");
    checks++;
    if (ill_pulses !== 1) begin
      failures++; $display("FAIL illegal_pulses obs=%0d exp=1", ill_pulses);
    end
    drive(4'd0, 1'b0, 1'b0, OP_BAD);
    e = sbq.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL illegal_no_retire obs=%h exp=%h", obs, e); end
  endtask

  task automatic test_timeout();
    logic [24:0] e;
    do_reset();
    exec_instr(OP_R, 0, 0, "pre_fault");
    drive(4'd0, 1'b0, 1'b1, OP_R);
    e = sbq.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL to_idle obs=%h exp=%h", obs, e); end
    for (int i = 0; i < TO; i++) begin
      drive(4'd1, 1'b0, 1'b1, OP_R);
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL to_wait%0d obs=%h exp=%h", i, obs, e); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(4'd15, i[0], i != 1, OP_R);
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL to_sticky%0d obs=%h exp=%h", i, obs, e); end
    end
    do_reset();
    exec_instr(OP_R, TO - 1, 0, "fetch_ready_at_limit");
    exec_instr(OP_LW, 0, TO - 1, "memwait_ready_at_limit");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[8];
    logic [24:0] e;
    ops = '{OP_R, OP_ADDI, OP_BEQ, OP_SW, OP_LW, OP_R, OP_BEQ, OP_ADDI};
    do_reset();
    for (int i = 0; i < 8; i++) exec_instr(ops[i], i % 2, i % 3, "b2b");
    drive(4'd0, 1'b0, 1'b0, OP_ADDI);
    e = sbq.pop_front(); checks++;
    if (obs !== e || retired !== 3'd0) begin
      failures++; $display("FAIL b2b_wrap obs=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] sts[5];
    logic [24:0] e;
    exec_instr(OP_ADDI, 0, 0, "pre_mid");
    sts = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    for (int i = 0; i < 5; i++) begin
      drive(sts[i], i == 1, 1'b1, OP_LW);
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL mid_path%0d obs=%h exp=%h", i, obs, e); end
    end
    #2;
    reset_n = 0;
    exp_ret = 0;
    sbq.push_back(exp_vec(4'd0, 1'b0, OP_LW, 3'd0));
    #1;
    e = sbq.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL mid_reset obs=%h exp=%h", obs, e); end
    @(negedge clk);
    run = 0;
    reset_n = 1;
    exec_instr(OP_R, 0, 0, "post_mid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_r_type();
    test_lw();
    test_sw_beq();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
